// File: rtl/spi_master_pkg.sv
// Shared types and widths for the SPI master.
// Used by the transfer sequencer and its interface.
package spi_master_pkg;

    localparam int SPI_DATA_W = 64;
    localparam int SPI_BC_W   = 3;
    localparam int SPI_DL_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Register-block and pin bundle of the SPI transfer sequencer.
// master = sequencer view, slave = register block / pad view.
interface spi_xfer_ctrl_if;
    import spi_master_pkg::*;

    logic                  reg_clkgen_en;
    logic [SPI_DL_W-1:0]   reg_clkgen_dl;
    logic [SPI_BC_W-1:0]   reg_ctrl_bc;
    logic [SPI_DATA_W-1:0] reg_ctrl_tx_data;
    logic                  reg_ctrl_oe;
    logic                  reg_ctrl_tran;
    logic                  ctrl_reg_busy;
    logic [SPI_DATA_W-1:0] ctrl_reg_rx_data;
    logic                  ctrl_reg_rd_en;
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_mosi_oe;
    logic                  spi_miso;

    modport master (
        input  reg_clkgen_en, reg_clkgen_dl, reg_ctrl_bc,
        input  reg_ctrl_tx_data, reg_ctrl_oe, reg_ctrl_tran,
        input  spi_miso,
        output ctrl_reg_busy, ctrl_reg_rx_data, ctrl_reg_rd_en,
        output spi_sclk, spi_cs_n, spi_mosi, spi_mosi_oe
    );

    modport slave (
        output reg_clkgen_en, reg_clkgen_dl, reg_ctrl_bc,
        output reg_ctrl_tx_data, reg_ctrl_oe, reg_ctrl_tran,
        output spi_miso,
        input  ctrl_reg_busy, ctrl_reg_rx_data, ctrl_reg_rd_en,
        input  spi_sclk, spi_cs_n, spi_mosi, spi_mosi_oe
    );

endinterface

// File: rtl/spi_half_div.sv
// SCLK half-period counter: ticks when count == dl, then wraps.
// Counter is DL_W wide; dl=all-ones wraps naturally without overflow.
module spi_half_div #(
    parameter int DL_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [DL_W-1:0] dl,
    output logic            tick
);

    logic [DL_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == dl);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick)
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI frame sequencer (1..8 bytes, MSB first).
// All pin and register-block outputs come straight from flops.
module spi_xfer_ctrl
    import spi_master_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int BC_W   = SPI_BC_W,
    parameter int DL_W   = SPI_DL_W
) (
    input  logic            sys_clk,
    input  logic            rst,
    spi_xfer_ctrl_if.master bus
);

    localparam int CNT_W = 7;

    state_e              state_q, state_d;
    logic [DL_W-1:0]     dl_lat_q, dl_lat_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                busy_q, busy_d;
    logic                rd_en_q, rd_en_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                oe_q, oe_d;
    logic                tick;
    logic                div_clr;
    logic [5:0]          tx_shamt;

    // Every transition happens on a tick, which already wraps the
    // counter, so only idling/aborting needs an explicit clear.
    assign div_clr  = (state_q == ST_IDLE) || !bus.reg_clkgen_en;
    assign tx_shamt = {~bus.reg_ctrl_bc, 3'b000};

    spi_half_div #(.DL_W(DL_W)) u_div (
        .clk  (sys_clk),
        .rst  (rst),
        .clr  (div_clr),
        .dl   (dl_lat_q),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        dl_lat_d  = dl_lat_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        rd_en_d   = 1'b0;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        oe_d      = oe_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.reg_ctrl_tran && bus.reg_clkgen_en) begin
                    state_d   = ST_SETUP;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    dl_lat_d  = bus.reg_clkgen_dl;
                    bit_cnt_d = {1'b0, bus.reg_ctrl_bc, 3'b000} + 7'd8;
                    tx_sh_d   = bus.reg_ctrl_tx_data << tx_shamt;
                    rx_sh_d   = '0;
                    oe_d      = bus.reg_ctrl_oe;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (tick) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.spi_miso};
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    sclk_d    = 1'b0;
                    if (bit_cnt_q == 7'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOW;
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    oe_d      = 1'b0;
                    rd_en_d   = 1'b1;
                    rx_data_d = rx_sh_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !bus.reg_clkgen_en) begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dl_lat_q  <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_lat_q  <= dl_lat_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            oe_q      <= oe_d;
        end
    end

    assign bus.ctrl_reg_busy    = busy_q;
    assign bus.ctrl_reg_rx_data = rx_data_q;
    assign bus.ctrl_reg_rd_en   = rd_en_q;
    assign bus.spi_sclk         = sclk_q;
    assign bus.spi_cs_n         = cs_n_q;
    assign bus.spi_mosi         = tx_sh_q[DATA_W-1];
    assign bus.spi_mosi_oe      = oe_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: vector table, random frames vs. a frame model,
// plus abort, reset and back-to-back sequences.
module tb_spi_xfer_ctrl;
    import spi_master_pkg::*;

    typedef struct {
        logic [2:0]  bc;
        logic [15:0] dl;
        logic [63:0] tx;
        logic        oe;
        logic        inv;
        logic        tie1;
        logic [63:0] exp_rx;
        int          exp_lat;
    } vec_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic inv     = 1'b0;
    logic tie1    = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    logic [63:0] last_rx;
    vec_t vecs[5];

    spi_xfer_ctrl_if bus ();

    spi_xfer_ctrl dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    assign bus.spi_miso = tie1 ? 1'b1 : (bus.spi_mosi ^ inv);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] frame_mask(input logic [2:0] bc);
        int nb = 8 * (int'(bc) + 1);
        return (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    endfunction

    // What the slave side should end up holding after one frame.
    function automatic logic [63:0] model_rx(input vec_t v);
        if (v.tie1)
            return frame_mask(v.bc);
        return (v.tx ^ {64{v.inv}}) & frame_mask(v.bc);
    endfunction

    function automatic int model_lat(input logic [2:0] bc,
                                     input logic [15:0] dl);
        return (16 * (int'(bc) + 1) + 1) * (int'(dl) + 1);
    endfunction

    task automatic load(input vec_t v);
        bus.reg_ctrl_bc      = v.bc;
        bus.reg_clkgen_dl    = v.dl;
        bus.reg_ctrl_tx_data = v.tx;
        bus.reg_ctrl_oe      = v.oe;
        inv                  = v.inv;
        tie1                 = v.tie1;
    endtask

    task automatic run_frame(input string nm, input vec_t v);
        int          cyc;
        int          rises;
        logic [63:0] mseq;
        logic        prev_sclk;
        logic        oe_ok;
        logic        busy_ok;
        logic        done;
        load(v);
        bus.reg_clkgen_en = 1'b1;
        bus.reg_ctrl_tran = 1'b1;
        @(posedge sys_clk); #1;
        bus.reg_ctrl_tran = 1'b0;
        cyc = 0; rises = 0; mseq = '0; prev_sclk = 1'b0;
        oe_ok = 1'b1; busy_ok = 1'b1; done = 1'b0;
        while (!done && cyc < 20000) begin
            if (bus.spi_sclk && !prev_sclk) begin
                rises++;
                mseq = {mseq[62:0], bus.spi_mosi};
            end
            prev_sclk = bus.spi_sclk;
            if (bus.ctrl_reg_rd_en) begin
                done = 1'b1;
            end else begin
                if (bus.spi_cs_n || bus.spi_mosi_oe !== v.oe) oe_ok = 1'b0;
                if (bus.ctrl_reg_busy !== 1'b1) busy_ok = 1'b0;
                @(posedge sys_clk); #1;
                cyc++;
            end
        end
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_lat"}, 64'(cyc), 64'(v.exp_lat));
        chk({nm, "_rx"}, bus.ctrl_reg_rx_data, v.exp_rx);
        chk({nm, "_sclk_rises"}, 64'(rises), 64'(8 * (int'(v.bc) + 1)));
        chk({nm, "_mosi_seq"}, mseq, v.tx & frame_mask(v.bc));
        chk({nm, "_oe_busy_cs"}, {62'd0, oe_ok, busy_ok}, 64'd3);
        chk({nm, "_end_pins"},
            {60'd0, bus.spi_cs_n, bus.ctrl_reg_busy,
             bus.spi_mosi_oe, bus.spi_sclk}, 64'h8);
        @(posedge sys_clk); #1;
        chk({nm, "_rd_en_1cyc"}, 64'(bus.ctrl_reg_rd_en), 64'd0);
        last_rx = v.exp_rx;
    endtask

    task automatic check_reset_outs(input string nm);
        chk(nm, {bus.ctrl_reg_busy, bus.ctrl_reg_rd_en, bus.spi_sclk,
                 bus.spi_cs_n, bus.spi_mosi, bus.spi_mosi_oe},
            64'b000100);
        chk({nm, "_rx"}, bus.ctrl_reg_rx_data, 64'd0);
    endtask

    initial begin
        vec_t v;
        int   cyc;
        int   pulses;
        vecs[0] = '{3'd0, 16'd0, 64'hA5, 1'b1, 1'b0, 1'b0,
                    64'hA5, 17};
        vecs[1] = '{3'd7, 16'd3, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0,
                    64'h0123456789ABCDEF, 516};
        vecs[2] = '{3'd1, 16'd1, 64'h1234, 1'b0, 1'b0, 1'b1,
                    64'hFFFF, 66};
        vecs[3] = '{3'd0, 16'd255, 64'h3C, 1'b1, 1'b1, 1'b0,
                    64'hC3, 4352};
        vecs[4] = '{3'd3, 16'd2, 64'hFFFFFFFF_DEADBEEF, 1'b1, 1'b0, 1'b0,
                    64'hDEADBEEF, 195};

        bus.reg_clkgen_en    = 1'b0;
        bus.reg_clkgen_dl    = '0;
        bus.reg_ctrl_bc      = '0;
        bus.reg_ctrl_tx_data = '0;
        bus.reg_ctrl_oe      = 1'b0;
        bus.reg_ctrl_tran    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;
        @(posedge sys_clk); #1;

        for (int i = 0; i < 5; i++)
            run_frame($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v.bc   = 3'($urandom_range(0, 7));
            v.dl   = 16'($urandom_range(0, 4));
            v.tx   = {$urandom, $urandom};
            v.oe   = 1'($urandom_range(0, 1));
            v.inv  = 1'($urandom_range(0, 1));
            v.tie1 = 1'b0;
            v.exp_rx  = model_rx(v);
            v.exp_lat = model_lat(v.bc, v.dl);
            run_frame($sformatf("rnd%0d", i), v);
        end

        // Abort by dropping the engine enable mid-frame.
        v = '{3'd7, 16'd0, 64'h1122334455667788, 1'b1, 1'b0, 1'b0, 0, 0};
        load(v);
        bus.reg_ctrl_tran = 1'b1;
        @(posedge sys_clk); #1;
        bus.reg_ctrl_tran = 1'b0;
        repeat (19) @(posedge sys_clk);
        #1;
        bus.reg_clkgen_en = 1'b0;
        @(posedge sys_clk); #1;
        chk("abort_pins", {bus.spi_cs_n, bus.ctrl_reg_busy, bus.spi_sclk,
                           bus.spi_mosi_oe, bus.ctrl_reg_rd_en}, 64'b10000);
        chk("abort_rx_kept", bus.ctrl_reg_rx_data, last_rx);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge sys_clk); #1;
            if (bus.ctrl_reg_rd_en) pulses++;
        end
        chk("abort_no_rd_en", 64'(pulses), 64'd0);
        v.bc = 3'd2; v.dl = 16'd1; v.tx = 64'hABCDEF;
        v.exp_rx = model_rx(v); v.exp_lat = model_lat(v.bc, v.dl);
        run_frame("after_abort", v);

        // Asynchronous reset in the middle of a frame.
        v = '{3'd7, 16'd0, 64'h55AA55AA55AA55AA, 1'b1, 1'b0, 1'b0, 0, 0};
        load(v);
        bus.reg_ctrl_tran = 1'b1;
        @(posedge sys_clk); #1;
        bus.reg_ctrl_tran = 1'b0;
        repeat (10) @(posedge sys_clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outs("midframe_rst");
        @(posedge sys_clk); #1;
        rst = 1'b0;
        v.bc = 3'd1; v.tx = 64'h9A7E;
        v.exp_rx = model_rx(v); v.exp_lat = model_lat(v.bc, v.dl);
        run_frame("after_rst", v);

        // tran held high: back-to-back frames, mid-frame field changes.
        v = '{3'd0, 16'd0, 64'h5A, 1'b1, 1'b0, 1'b0, 64'h5A, 17};
        load(v);
        bus.reg_ctrl_tran = 1'b1;
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            @(posedge sys_clk); #1;
            chk($sformatf("b2b%0d_start", f),
                {bus.ctrl_reg_busy, bus.spi_cs_n}, 64'b10);
            cyc = 0;
            while (!bus.ctrl_reg_rd_en && cyc < 200) begin
                if (cyc == 5) begin
                    bus.reg_ctrl_bc   = 3'd7;
                    bus.reg_clkgen_dl = 16'd3;
                end
                @(posedge sys_clk); #1;
                cyc++;
            end
            pulses++;
            chk($sformatf("b2b%0d_lat", f), 64'(cyc), 64'd17);
            chk($sformatf("b2b%0d_rx", f), bus.ctrl_reg_rx_data, 64'h5A);
            chk($sformatf("b2b%0d_idle_gap", f),
                {bus.spi_cs_n, bus.ctrl_reg_busy}, 64'b10);
            bus.reg_ctrl_bc   = 3'd0;
            bus.reg_clkgen_dl = 16'd0;
            if (f == 2) bus.reg_ctrl_tran = 1'b0;
        end
        @(posedge sys_clk); #1;
        chk("b2b_stop", {bus.ctrl_reg_busy, bus.spi_cs_n,
                         bus.ctrl_reg_rd_en}, 64'b010);
        chk("b2b_pulses", 64'(pulses), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the APB SPI master. It consumes the configuration and TX data held by the SPI register block. It runs one mode-0 SPI frame (CPOL=0, CPHA=0, MSB first) of 1..8 bytes on the pins, generating SCLK from a programmable half-period divider. On completion it hands the captured RX word back to the register block.

Parameters:
DATA_W, 64, TX/RX word width (8 bytes max)
BC_W, 3, byte-count field width; frame length = bc+1 bytes
DL_W, 16, divider field width

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
reg_clkgen_en  in  1  engine enable; low aborts/blocks transfers
reg_clkgen_dl  in  DL_W  half-period = dl+1 sys_clk cycles
reg_ctrl_bc  in  BC_W  bytes-1
reg_ctrl_tx_data  in  DATA_W  TX word, right-justified
reg_ctrl_oe  in  1  MOSI output-enable request
reg_ctrl_tran  in  1  start request (level; register block clears it on busy)
ctrl_reg_busy  out  1  transfer in progress
ctrl_reg_rx_data  out  DATA_W  captured RX word, right-justified
ctrl_reg_rd_en  out  1  1-cycle pulse: rx_data valid, load RX buffers
spi_sclk  out  1  SPI clock
spi_cs_n  out  1  chip select, active low
spi_mosi  out  1  serial out
spi_mosi_oe  out  1  MOSI pad enable
spi_miso  in  1  serial in (pre-synchronised externally)

Behaviour:
- Reset values (async): state IDLE, busy=0, rd_en=0, rx_data=0, sclk=0, cs_n=1, mosi=0, mosi_oe=0, counters=0.
- States: IDLE, SETUP, HIGH, LOW, HOLD. All outputs are registered.
- Half-period counter: counts 0..dl_lat and ticks in the cycle where count==dl_lat, then wraps to 0. It is cleared on every state entry.
- IDLE -> SETUP when tran && clkgen_en.
  - At that edge: busy=1, cs_n=0.
  - Latch dl_lat=dl and n=8*(bc+1).
  - Load the TX shifter with tx_data left-justified (shift left by 8*(7-bc)); mosi = its MSB.
  - mosi_oe = reg_ctrl_oe, sampled at start and held for the frame.
- SETUP --tick--> HIGH: sclk=1; shift miso into RX shifter LSB.
- HIGH --tick--> decrement bit count.
  - If the count reaches 0: go HOLD; sclk=0.
  - Otherwise: go LOW; sclk=0; shift TX left so mosi = next bit.
- LOW --tick--> HIGH: sclk=1; sample miso.
- HOLD --tick--> IDLE:
  - cs_n=1, busy=0, mosi_oe=0.
  - rd_en=1 for exactly one cycle.
  - rx_data = RX shifter, zero-extended to 64 bits (bits above 8*(bc+1) are 0).
- Latency: start edge to the rd_en cycle is exactly (2n+1)*(dl_lat+1) sys_clk cycles. The frame has n SCLK rising edges.
- After completion, IDLE lasts at least 1 cycle before a new start is accepted.
- tran while busy is ignored.
- Changes to dl, bc, tx_data or oe mid-frame have no effect; all are latched at start.
- clkgen_en low in any non-IDLE state: next edge goes to IDLE.
  - Outputs: cs_n=1, sclk=0, busy=0, mosi_oe=0.
  - No rd_en pulse; rx_data unchanged.
- rst mid-frame: immediate return to reset values; no rd_en.
- dl=0: SCLK = sys_clk/2.
- dl=0xFFFF: counter must not overflow (DL_W+1 not required; counter is DL_W wide).

Decomposition:
- Shared package spi_master_pkg: state encoding, SPI_DATA_W=64, SPI_BC_W=3, SPI_DL_W=16.
- One natural sub-module, spi_half_div: counter with clear, dl input and tick output.

Test Plan:
1. bc=0, tx=0xA5, dl=0, miso looped to mosi, oe=1, tran pulse.
   -> 8 SCLK rising edges; mosi sequence 1,0,1,0,0,1,0,1; rd_en at cycle 17 after start; rx_data=0x00000000000000A5; mosi_oe high only while cs_n low.
2. bc=7, tx=0x0123456789ABCDEF, dl=3, loopback.
   -> rd_en at cycle 516 (129*4); rx_data=0x0123456789ABCDEF; SCLK high/low each 4 cycles.
3. bc=1, dl=1, miso tied 1.
   -> rd_en at cycle 66; rx_data=0x000000000000FFFF; busy high cycles 1..65.
4. Start bc=7, dl=0; drop clkgen_en at cycle 20.
   -> cycle 21: cs_n=1, busy=0, sclk=0; no rd_en; rx_data keeps its prior value. A following new transfer completes normally.
5. Assert rst at cycle 10 of a frame.
   -> outputs take reset values in the same cycle. After release, tran+en starts a clean frame with the correct result.
6. Hold tran high continuously with bc=0, dl=0.
   -> back-to-back frames separated by at least 1 IDLE cycle with cs_n=1; exactly one rd_en per frame; dl/bc changes mid-frame are ignored.
